// File: rtl/video_pkg.sv
// Shared definitions for the video timing path: standard timing sets,
// raster total helpers, RGB packing and the sideband flag bundle.
package video_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } timing_t;

  localparam timing_t TIMING_640X480_60 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  localparam timing_t TIMING_800X600_60 = '{
    h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
  };

  // Raster counter and coordinate widths
  localparam int CNT_W   = 11;
  localparam int COORD_W = 10;

  // 24-bit pixel word is {R[23:16], G[15:8], B[7:0]}
  localparam int CH_W  = 8;
  localparam int RGB_W = 3 * CH_W;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Sideband flags that travel alongside a pixel read. Sync bits are
  // carried at their output polarity so the idle pattern is directly usable.
  typedef struct packed {
    logic first;
    logic vs;
    logic hs;
    logic de;
  } flags_t;

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input timing_t t);
    return line_total(t.h_active, t.h_fp, t.h_sync, t.h_bp);
  endfunction

  function automatic int v_total(input timing_t t);
    return line_total(t.v_active, t.v_fp, t.v_sync, t.v_bp);
  endfunction

  function automatic logic [RGB_W-1:0] rgb_pack(input logic [CH_W-1:0] r,
                                                input logic [CH_W-1:0] g,
                                                input logic [CH_W-1:0] b);
    return {r, g, b};
  endfunction

  function automatic logic [CH_W-1:0] rgb_red(input logic [RGB_W-1:0] p);
    return p[R_LSB +: CH_W];
  endfunction

  function automatic logic [CH_W-1:0] rgb_green(input logic [RGB_W-1:0] p);
    return p[G_LSB +: CH_W];
  endfunction

  function automatic logic [CH_W-1:0] rgb_blue(input logic [RGB_W-1:0] p);
    return p[B_LSB +: CH_W];
  endfunction

endpackage

// File: rtl/sig_delay.sv
// Fixed-depth shift register with asynchronous active-low clear to a
// configurable idle pattern.
module sig_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // Shift din through DEPTH stages; clear every stage to the idle pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= RST_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with a fixed-latency pixel fetch. Stage F issues
// the read and launches the sideband flags; the flags wait FETCH_LAT cycles
// in sig_delay so that stage O sees them together with the returned pixel.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE       = TIMING_640X480_60.h_active,
  parameter int H_FP           = TIMING_640X480_60.h_fp,
  parameter int H_SYNC         = TIMING_640X480_60.h_sync,
  parameter int H_BP           = TIMING_640X480_60.h_bp,
  parameter int V_ACTIVE       = TIMING_640X480_60.v_active,
  parameter int V_FP           = TIMING_640X480_60.v_fp,
  parameter int V_SYNC         = TIMING_640X480_60.v_sync,
  parameter int V_BP           = TIMING_640X480_60.v_bp,
  parameter int HS_ACTIVE_HIGH = 0,
  parameter int VS_ACTIVE_HIGH = 0,
  parameter int FETCH_LAT      = 2
) (
  input  logic               pixclk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               fetch_req,
  output logic [COORD_W-1:0] fetch_x,
  output logic [COORD_W-1:0] fetch_y,
  input  logic [RGB_W-1:0]   pix_in,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic               vde,
  output logic               hSync,
  output logic               vSync,
  output logic               frame_start
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON  = (HS_ACTIVE_HIGH != 0);
  localparam logic HS_OFF = !HS_ON;
  localparam logic VS_ON  = (VS_ACTIVE_HIGH != 0);
  localparam logic VS_OFF = !VS_ON;

  // Blank pixel with both syncs inactive; also the reset pattern of the flag pipe
  localparam flags_t FLAGS_IDLE = '{first: 1'b0, vs: VS_OFF, hs: HS_OFF, de: 1'b0};

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             in_active;
  logic             in_hs;
  logic             in_vs;
  logic             at_origin;
  flags_t           flags_next;
  flags_t           flags_f;
  flags_t           flags_d;

  // Raster counters; held at the origin while disabled so a restart begins at (0,0)
  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (!enable) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Region decode for the current raster position; vsync is judged per line
  always_comb begin
    in_active  = (hcnt < H_ACT) && (vcnt < V_ACT);
    in_hs      = (hcnt >= HS_BEGIN) && (hcnt < HS_END);
    in_vs      = (vcnt >= VS_BEGIN) && (vcnt < VS_END);
    at_origin  = (hcnt == '0) && (vcnt == '0);
    flags_next = FLAGS_IDLE;
    if (enable) begin
      flags_next.de    = in_active;
      flags_next.hs    = in_hs ? HS_ON : HS_OFF;
      flags_next.vs    = in_vs ? VS_ON : VS_OFF;
      flags_next.first = in_active && at_origin;
    end
  end

  // Stage F: issue the pixel read and launch the matching sideband flags
  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_req <= 1'b0;
      fetch_x   <= '0;
      fetch_y   <= '0;
      flags_f   <= FLAGS_IDLE;
    end else begin
      fetch_req <= flags_next.de;
      fetch_x   <= flags_next.de ? hcnt[COORD_W-1:0] : '0;
      fetch_y   <= flags_next.de ? vcnt[COORD_W-1:0] : '0;
      flags_f   <= flags_next;
    end
  end

  sig_delay #(
    .WIDTH   ($bits(flags_t)),
    .DEPTH   (FETCH_LAT),
    .RST_VAL (FLAGS_IDLE)
  ) u_flag_dly (
    .clk   (pixclk),
    .rst_n (reset_n),
    .din   (flags_f),
    .dout  (flags_d)
  );

  // Stage O: merge returned pixel with its delayed flags; blank RGB outside active video
  always_ff @(posedge pixclk or negedge reset_n) begin
    if (!reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      vde         <= 1'b0;
      hSync       <= HS_OFF;
      vSync       <= VS_OFF;
      frame_start <= 1'b0;
    end else begin
      red         <= flags_d.de ? rgb_red(pix_in)   : '0;
      green       <= flags_d.de ? rgb_green(pix_in) : '0;
      blue        <= flags_d.de ? rgb_blue(pix_in)  : '0;
      vde         <= flags_d.de;
      hSync       <= flags_d.hs;
      vSync       <= flags_d.vs;
      frame_start <= flags_d.first;
    end
  end

endmodule
